// File: rtl/clipper_ram_req_port.sv
// rtl/clipper_ram_req_port.sv - RLDRAM3 request port: command accept, request issue, read tag tracking
module clipper_ram_req_port #(
    parameter int G_BANK_W    = 4,
    parameter int G_ADDR_W    = 21,
    parameter int G_DAT_W     = 72,
    parameter int G_DM_W      = 4,
    parameter int G_TAG_W     = 4,
    parameter int G_MAX_OUTST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [G_BANK_W-1:0] cmd_bank,
    input  logic [G_ADDR_W-1:0] cmd_row_col,
    input  logic [G_DAT_W-1:0]  cmd_data,
    input  logic [G_DM_W-1:0]   cmd_dm,
    input  logic [G_TAG_W-1:0]  cmd_tag,
    output logic                rsp_valid,
    output logic [G_TAG_W-1:0]  rsp_tag,
    output logic [G_DAT_W-1:0]  rsp_data,
    output logic [G_BANK_W-1:0] bk_addr,
    output logic [G_ADDR_W-1:0] row_col_addr,
    output logic                wr_req,
    output logic                rd_req,
    output logic [G_DM_W-1:0]   dm,
    output logic [G_DAT_W-1:0]  wr_data,
    input  logic                req_bus_afull,
    input  logic                busy,
    input  logic                rd_data_rdy,
    input  logic [G_DAT_W-1:0]  rd_data,
    input  logic                init_done,
    input  logic                cal_fail,
    output logic                err_unexp,
    output logic                err_cal
);

    localparam int PTR_W = (G_MAX_OUTST > 1) ? $clog2(G_MAX_OUTST) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [G_TAG_W-1:0]  tag_mem [G_MAX_OUTST];

    logic                wr_req_q, rd_req_q, rsp_valid_q;
    logic [G_BANK_W-1:0] bk_addr_q;
    logic [G_ADDR_W-1:0] row_col_q;
    logic [G_DAT_W-1:0]  wr_data_q, rsp_data_q;
    logic [G_DM_W-1:0]   dm_q;
    logic [G_TAG_W-1:0]  rsp_tag_q;
    logic                err_unexp_q, err_cal_q;

    logic accept, acc_wr, acc_rd, pop, unexp;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: calibration failure wins over init completion; FAIL is terminal until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (cal_fail) begin
                    state_d = ST_FAIL;
                end else if (init_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cal_fail) begin
                    state_d = ST_FAIL;
                end
            end
            default: state_d = ST_FAIL;
        endcase
    end

    // Outputs from state: ready only in RUN with RAM headroom and a free tag slot
    always_comb begin
        cmd_ready = (state_q == ST_RUN) && !req_bus_afull && !busy
                    && (count_q < CNT_W'(G_MAX_OUTST));
    end

    // Handshake and tag FIFO control; a pop needs a tag already present before this cycle
    always_comb begin
        accept  = cmd_valid && cmd_ready;
        acc_wr  = accept && cmd_wr;
        acc_rd  = accept && !cmd_wr;
        pop     = rd_data_rdy && (count_q != '0);
        unexp   = rd_data_rdy && (count_q == '0);
        count_d = count_q;
        if (acc_rd && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !acc_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (acc_rd) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Tag storage; contents are meaningless while the pointers say empty, so no reset
    always_ff @(posedge clk) begin
        if (acc_rd) begin
            tag_mem[wr_ptr_q] <= cmd_tag;
        end
    end

    // Request issue: one-cycle pulses, address/data held between requests
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            bk_addr_q <= '0;
            row_col_q <= '0;
            wr_data_q <= '0;
            dm_q      <= '0;
        end else begin
            wr_req_q <= acc_wr;
            rd_req_q <= acc_rd;
            if (accept) begin
                bk_addr_q <= cmd_bank;
                row_col_q <= cmd_row_col;
            end
            if (acc_wr) begin
                wr_data_q <= cmd_data;
                dm_q      <= cmd_dm;
            end else if (acc_rd) begin
                dm_q      <= '0;
            end
        end
    end

    // Read response: pair returning data with the oldest outstanding tag
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= pop;
            if (pop) begin
                rsp_tag_q  <= tag_mem[rd_ptr_q];
                rsp_data_q <= rd_data;
            end
        end
    end

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_unexp_q <= 1'b0;
            err_cal_q   <= 1'b0;
        end else begin
            if (unexp) begin
                err_unexp_q <= 1'b1;
            end
            if ((state_d == ST_FAIL) && (state_q != ST_FAIL)) begin
                err_cal_q <= 1'b1;
            end
        end
    end

    assign wr_req       = wr_req_q;
    assign rd_req       = rd_req_q;
    assign bk_addr      = bk_addr_q;
    assign row_col_addr = row_col_q;
    assign wr_data      = wr_data_q;
    assign dm           = dm_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_data     = rsp_data_q;
    assign err_unexp    = err_unexp_q;
    assign err_cal      = err_cal_q;

endmodule

// File: doc/clipper_ram_req_port.md
CLIPPER_RAM_REQ_PORT -- requirements
Module: clipper_ram_req_port

Interface
REQ-001 SHALL have parameter G_BANK_W, default 4, meaning RLDRAM3 bank address width.
REQ-002 SHALL have parameter G_ADDR_W, default 21, meaning row/column address width.
REQ-003 SHALL have parameter G_DAT_W, default 72, meaning burst data width (burst_len 2 x 36).
REQ-004 SHALL have parameter G_DM_W, default 4, meaning burst data-mask width (burst_len 2 x 2).
REQ-005 SHALL have parameter G_TAG_W, default 4, meaning read tag width.
REQ-006 SHALL have parameter G_MAX_OUTST, default 8 (power of 2, 2..16), meaning max outstanding reads.
REQ-007 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_wr  in  1  1=write, 0=read
- cmd_bank  in  G_BANK_W  bank address
- cmd_row_col  in  G_ADDR_W  row/column address
- cmd_data  in  G_DAT_W  write data
- cmd_dm  in  G_DM_W  write mask
- cmd_tag  in  G_TAG_W  read tag
- rsp_valid  out  1  read response pulse (no backpressure)
- rsp_tag  out  G_TAG_W  tag of returned read
- rsp_data  out  G_DAT_W  returned read data
- bk_addr  out  G_BANK_W  to RAM unit
- row_col_addr  out  G_ADDR_W  to RAM unit
- wr_req  out  1  write request pulse
- rd_req  out  1  read request pulse
- dm  out  G_DM_W  write mask to RAM
- wr_data  out  G_DAT_W  write data to RAM
- req_bus_afull  in  1  RAM request bus almost full
- busy  in  1  RAM unit busy
- rd_data_rdy  in  1  RAM read data valid pulse
- rd_data  in  G_DAT_W  RAM read data
- init_done  in  1  RAM init complete
- cal_fail  in  1  RAM calibration failed
- err_unexp  out  1  sticky: read data with no outstanding read
- err_cal  out  1  sticky: calibration failure seen

Function
REQ-008 SHALL implement FSM INIT, RUN, FAIL; INIT->RUN when init_done=1 and cal_fail=0; INIT or RUN->FAIL when cal_fail=1; FAIL exits only by reset.
REQ-009 SHALL drive cmd_ready=1 only when state=RUN, req_bus_afull=0, busy=0, and outstanding count < G_MAX_OUTST; cmd_ready SHALL NOT depend on cmd_valid or cmd_wr.
REQ-010 SHALL on accepted write, in the next cycle, pulse wr_req=1 for exactly one cycle with bk_addr, row_col_addr, wr_data, dm registered from the command.
REQ-011 SHALL on accepted read, in the next cycle, pulse rd_req=1 for exactly one cycle with bk_addr, row_col_addr registered, dm=0, and push cmd_tag into a G_MAX_OUTST-deep tag FIFO.
REQ-012 SHALL hold bk_addr, row_col_addr, wr_data, dm at last values when no request is issued.
REQ-013 SHALL on rd_data_rdy=1 with FIFO non-empty pop the oldest tag and, next cycle, pulse rsp_valid=1 with rsp_tag=popped tag and rsp_data=rd_data registered.
REQ-014 SHALL on rd_data_rdy=1 with FIFO empty set err_unexp=1, leave rsp_valid=0, and not alter the count.
REQ-015 SHALL on simultaneous push and pop keep count unchanged; FIFO pointers wrap modulo G_MAX_OUTST.
REQ-016 SHALL accept at most one command per cycle; back-to-back accepts allowed at full rate while cmd_ready=1.
REQ-017 SHALL set err_cal=1 on entry to FAIL; in FAIL, responses for outstanding reads SHALL still be returned.

Reset
REQ-018 SHALL, when rst=0 at a rising edge, set state=INIT, cmd_ready=0, wr_req=0, rd_req=0, rsp_valid=0, bk_addr=0, row_col_addr=0, wr_data=0, dm=0, rsp_tag=0, rsp_data=0, err_unexp=0, err_cal=0, FIFO empty, count=0.
REQ-019 SHALL discard all outstanding read tags on reset mid-operation; subsequent rd_data_rdy with empty FIFO SHALL set err_unexp.

Verification
REQ-020 SHALL cover: init_done=0 with cmd_valid=1 -> cmd_ready=0, no wr_req/rd_req; init_done=1 -> cmd_ready=1 next cycle.
REQ-021 SHALL cover: write bank=3, row_col=0x1A5, data=0xDEAD -> wr_req one cycle later, bk_addr=3, row_col_addr=0x1A5, wr_data=0xDEAD.
REQ-022 SHALL cover: 8 reads tags 0..7 without return -> cmd_ready=0 after 8th; one rd_data_rdy -> rsp_tag=0, cmd_ready=1 again.
REQ-023 SHALL cover: read accept and rd_data_rdy in same cycle at count=3 -> count stays 3, responses in tag order.
REQ-024 SHALL cover: rd_data_rdy with no outstanding read -> err_unexp=1, rsp_valid=0; cal_fail=1 -> err_cal=1, cmd_ready=0 until reset.
REQ-025 SHALL cover: reset with 2 reads outstanding -> all outputs at reset values, count=0.
